// File: rtl/instr_fetch.sv
// Instruction fetch front-end: sequential fetch, one-cycle imem latency,
// prefetch FIFO to decode, and redirect flush/restart.
module instr_fetch #(
  parameter int ADDRWIDTH = 32,
  parameter int DATAWIDTH = 32,
  parameter logic [ADDRWIDTH-1:0] RESET_PC = '0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 cpu_rst,
  output logic [ADDRWIDTH-1:0] instr_rd_addr,
  input  logic [DATAWIDTH-1:0] instr_rd_data,
  output logic                 dec_valid,
  output logic [DATAWIDTH-1:0] dec_instr,
  output logic [ADDRWIDTH-1:0] dec_pc,
  input  logic                 dec_ready,
  input  logic                 redirect_valid,
  input  logic [ADDRWIDTH-1:0] redirect_pc
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [ADDRWIDTH-1:0] fetch_pc;
  logic [ADDRWIDTH-1:0] rsp_pc;
  logic                 rsp_pending;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;

  logic [ADDRWIDTH-1:0] pc_q  [FIFO_DEPTH];
  logic [DATAWIDTH-1:0] ins_q [FIFO_DEPTH];

  logic                 issue;
  logic                 push;
  logic                 pop;
  logic [ADDRWIDTH-1:0] redir_aligned;

  // credit check uses current count only; a same-cycle pop gives no credit
  assign issue = !redirect_valid &&
                 ((count + CW'(rsp_pending)) < CW'(FIFO_DEPTH));
  assign push  = rsp_pending && !redirect_valid;
  assign pop   = dec_valid && dec_ready;

  assign redir_aligned = redirect_pc & ~ADDRWIDTH'(3);

  assign instr_rd_addr = {2'b00, fetch_pc[ADDRWIDTH-1:2]};

  assign dec_valid = (count != '0);
  assign dec_instr = dec_valid ? ins_q[rd_ptr] : '0;
  assign dec_pc    = dec_valid ? pc_q[rd_ptr]  : '0;

  // fetch address and in-flight request tracking
  always_ff @(posedge clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pending <= 1'b0;
      rsp_pc      <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= redir_aligned;
      rsp_pending <= 1'b0;
    end else if (issue) begin
      fetch_pc    <= fetch_pc + ADDRWIDTH'(4);
      rsp_pending <= 1'b1;
      rsp_pc      <= fetch_pc;
    end else begin
      rsp_pending <= 1'b0;
    end
  end

  // prefetch FIFO pointers and occupancy; redirect empties it
  always_ff @(posedge clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
    end
  end

  // FIFO storage, written with the returning imem word and its PC
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr]  <= rsp_pc;
      ins_q[wr_ptr] <= instr_rd_data;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomised and directed bench for instr_fetch, checked against a
// PC-stream reference model and a behavioural imem.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        cpu_rst = 1'b0;
  logic [31:0] instr_rd_addr;
  logic [31:0] instr_rd_data = '0;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  int n_cmp = 0;
  int n_bad = 0;

  instr_fetch #(
    .ADDRWIDTH(32),
    .DATAWIDTH(32),
    .RESET_PC(32'h0),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .cpu_rst(cpu_rst),
    .instr_rd_addr(instr_rd_addr),
    .instr_rd_data(instr_rd_data),
    .dec_valid(dec_valid),
    .dec_instr(dec_instr),
    .dec_pc(dec_pc),
    .dec_ready(dec_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] waddr);
    return 32'h1000 + waddr;
  endfunction

  // imem: one-cycle registered read
  always @(posedge clk) instr_rd_data <= imem(instr_rd_addr);

  function automatic logic [31:0] ahead(input logic [31:0] a,
                                        input logic [31:0] pc);
    return {a[29:0], 2'b00} - pc;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // leaves the bench 1ns into cycle 0 after release
  task automatic do_reset();
    dec_ready = 1'b0;
    redirect_valid = 1'b0;
    cpu_rst = 1'b1;
    @(posedge clk);
    #1;
    cpu_rst = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    cpu_rst = 1'b1;
    #1;
    n_cmp++;
    if (instr_rd_addr !== 32'h0 || dec_valid !== 1'b0 ||
        dec_instr !== 32'h0 || dec_pc !== 32'h0) begin
      n_bad++;
      $display("FAIL reset: addr=%h v=%b i=%h pc=%h want 0/0/0/0",
               instr_rd_addr, dec_valid, dec_instr, dec_pc);
    end
  endtask

  task automatic test_stream();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      dec_ready = 1'b1;
      n_cmp++;
      if (dec_valid !== (c >= 2)) begin
        n_bad++;
        $display("FAIL stream_valid c=%0d: got %b want %b",
                 c, dec_valid, c >= 2);
      end
      if (c >= 2) begin
        n_cmp++;
        if (dec_pc !== 32'(4 * (c - 2)) ||
            dec_instr !== imem(32'(c - 2))) begin
          n_bad++;
          $display("FAIL stream_data c=%0d: got %h/%h want %h/%h", c,
                   dec_pc, dec_instr, 32'(4 * (c - 2)), imem(32'(c - 2)));
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc;
    logic [31:0] held;
    do_reset();
    exp_pc = 0;
    held = 0;
    for (int c = 0; c < 25; c++) begin
      dec_ready = !(c >= 3 && c <= 12);
      if (c == 11) held = instr_rd_addr;
      if (c == 12) begin
        n_cmp++;
        if (instr_rd_addr !== held ||
            ahead(instr_rd_addr, dec_pc) !== 32'd16) begin
          n_bad++;
          $display("FAIL bp_full: addr=%h prev=%h ahead=%0d want ahead 16",
                   instr_rd_addr, held, ahead(instr_rd_addr, dec_pc));
        end
      end
      if (c >= 13) begin
        n_cmp++;
        if (dec_valid !== 1'b1) begin
          n_bad++;
          $display("FAIL bp_valid c=%0d: got %b want 1", c, dec_valid);
        end
      end
      if (dec_valid && dec_ready) begin
        n_cmp++;
        if (dec_pc !== exp_pc || dec_instr !== imem(exp_pc >> 2)) begin
          n_bad++;
          $display("FAIL bp_order c=%0d: got %h/%h want %h/%h", c,
                   dec_pc, dec_instr, exp_pc, imem(exp_pc >> 2));
        end
        exp_pc += 4;
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int c = 0; c < 13; c++) begin
      dec_ready = 1'b1;
      redirect_valid = (c == 8);
      redirect_pc = 32'h103;
      if (c >= 2 && c <= 8) begin
        n_cmp++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'(4 * (c - 2))) begin
          n_bad++;
          $display("FAIL redir_pre c=%0d: v=%b pc=%h want 1/%h",
                   c, dec_valid, dec_pc, 32'(4 * (c - 2)));
        end
      end
      if (c == 9 || c == 10) begin
        n_cmp++;
        if (dec_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL redir_gap c=%0d: got %b want 0", c, dec_valid);
        end
      end
      if (c >= 11) begin
        n_cmp++;
        if (dec_valid !== 1'b1 ||
            dec_pc !== 32'(32'h100 + 4 * (c - 11)) ||
            dec_instr !== imem(32'(32'h40 + c - 11))) begin
          n_bad++;
          $display("FAIL redir_post c=%0d: v=%b %h/%h want 1/%h/%h", c,
                   dec_valid, dec_pc, dec_instr,
                   32'(32'h100 + 4 * (c - 11)), imem(32'(32'h40 + c - 11)));
        end
      end
      tick();
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_wrap();
    logic [31:0] w;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      dec_ready = 1'b1;
      redirect_valid = (c == 3);
      redirect_pc = 32'hFFFF_FFFC;
      if (c >= 6) begin
        w = (c == 6) ? 32'hFFFF_FFFC : 32'h0;
        n_cmp++;
        if (dec_valid !== 1'b1 || dec_pc !== w ||
            dec_instr !== imem(w >> 2)) begin
          n_bad++;
          $display("FAIL wrap c=%0d: v=%b %h/%h want 1/%h/%h", c,
                   dec_valid, dec_pc, dec_instr, w, imem(w >> 2));
        end
      end
      tick();
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_midreset();
    do_reset();
    for (int c = 0; c < 10; c++) tick();
    n_cmp++;
    if (dec_valid !== 1'b1 || ahead(instr_rd_addr, dec_pc) !== 32'd16) begin
      n_bad++;
      $display("FAIL mid_full: v=%b ahead=%0d want 1/16",
               dec_valid, ahead(instr_rd_addr, dec_pc));
    end
    #3;
    cpu_rst = 1'b1;
    #1;
    n_cmp++;
    if (instr_rd_addr !== 32'h0 || dec_valid !== 1'b0 ||
        dec_instr !== 32'h0 || dec_pc !== 32'h0) begin
      n_bad++;
      $display("FAIL mid_async: addr=%h v=%b i=%h pc=%h want 0/0/0/0",
               instr_rd_addr, dec_valid, dec_instr, dec_pc);
    end
    @(posedge clk);
    #1;
    cpu_rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      dec_ready = 1'b1;
      n_cmp++;
      if (dec_valid !== (c >= 2) ||
          (c >= 2 && dec_pc !== 32'(4 * (c - 2)))) begin
        n_bad++;
        $display("FAIL mid_restart c=%0d: v=%b pc=%h", c, dec_valid, dec_pc);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] rpc;
    logic        rdy;
    logic        rv;
    int          since;
    do_reset();
    exp_pc = 0;
    since = 1;
    for (int c = 0; c < 600; c++) begin
      rdy = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 19) == 0);
      rpc = $urandom;
      dec_ready = rdy;
      redirect_valid = rv;
      redirect_pc = rpc;
      if (since == 1 || since == 2 || since == 3) begin
        n_cmp++;
        if (dec_valid !== (since == 3)) begin
          n_bad++;
          $display("FAIL rnd_latency c=%0d since=%0d: got %b want %b",
                   c, since, dec_valid, since == 3);
        end
      end
      if (dec_valid) begin
        n_cmp++;
        if (ahead(instr_rd_addr, dec_pc) > 32'd16) begin
          n_bad++;
          $display("FAIL rnd_overflow c=%0d: ahead=%0d want <=16",
                   c, ahead(instr_rd_addr, dec_pc));
        end
      end
      if (dec_valid && rdy) begin
        n_cmp++;
        if (dec_pc !== exp_pc || dec_instr !== imem(exp_pc >> 2)) begin
          n_bad++;
          $display("FAIL rnd_order c=%0d: got %h/%h want %h/%h", c,
                   dec_pc, dec_instr, exp_pc, imem(exp_pc >> 2));
        end
        exp_pc += 4;
      end
      if (rv) begin
        exp_pc = rpc & ~32'd3;
        since = 0;
      end
      tick();
      if (since < 100) since++;
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_midreset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
